systolic_feeder: RTL and testbench

SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

---
 rtl/systolic_feeder.sv | 116 +++++++++++
 tb/tb_systolic_feeder.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_feeder.sv
// Operand feeder for an N x N systolic array: holds A/B row buffers and drives skewed edge lanes.
// Optional feed-cycle performance counter enabled by defining SYSTOLIC_FEEDER_PERF_CNT_EN.
module systolic_feeder #(
  parameter int DATA_W = 8,
  parameter int N      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic                  wr_sel,
  input  logic [$clog2(N)-1:0]  wr_row,
  input  logic [N*DATA_W-1:0]   wr_data,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pe_rst,
  output logic                  pe_en,
  output logic [N*DATA_W-1:0]   a_edge,
  output logic [N*DATA_W-1:0]   b_edge,
  output logic [31:0]           feed_cycles,
  output logic [1:0]            dbg_state
);

  localparam int T_W = $clog2(3 * N);
  localparam logic [T_W-1:0] T_LAST = T_W'(3 * N - 3);

  // Handshake: a row write happens on any cycle where wr_valid && wr_ready;
  // wr_ready depends only on the FSM (high in IDLE) and never on wr_valid.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_FEED  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [T_W-1:0]      r_t;
  logic [DATA_W-1:0]   r_a [N][N];
  logic [DATA_W-1:0]   r_b [N][N];
  logic                w_wr_fire;

  assign w_wr_fire = wr_valid && wr_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_t     <= '0;
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          r_a[r][c] <= '0;
          r_b[r][c] <= '0;
        end
      end
    end else begin
      r_state <= w_next;
      r_t     <= (r_state == S_FEED) ? r_t + T_W'(1) : '0;
      if (w_wr_fire) begin
        for (int k = 0; k < N; k++) begin
          if (wr_sel) r_b[wr_row][k] <= wr_data[k*DATA_W +: DATA_W];
          else        r_a[wr_row][k] <= wr_data[k*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_CLEAR;
      S_CLEAR: w_next = S_FEED;
      S_FEED:  if (r_t == T_LAST) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign wr_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign pe_rst    = (r_state == S_CLEAR);
  assign pe_en     = (r_state == S_FEED);
  assign dbg_state = r_state;

  // Row i of A enters at lane i skewed by i cycles: lane i carries A[i][k] when t == i + k.
  // Column j of B likewise: lane j carries B[k][j] when t == j + k.
  always_comb begin
    a_edge = '0;
    b_edge = '0;
    if (r_state == S_FEED) begin
      for (int i = 0; i < N; i++) begin
        for (int k = 0; k < N; k++) begin
          if (int'(r_t) == i + k) begin
            a_edge[i*DATA_W +: DATA_W] = r_a[i][k];
            b_edge[i*DATA_W +: DATA_W] = r_b[k][i];
          end
        end
      end
    end
  end

`ifdef SYSTOLIC_FEEDER_PERF_CNT_EN
  logic [31:0] r_feed_cycles;

  always_ff @(posedge clk) begin
    if (rst)                    r_feed_cycles <= '0;
    else if (r_state == S_FEED) r_feed_cycles <= r_feed_cycles + 32'd1;
  end

  assign feed_cycles = r_feed_cycles;
`else
  assign feed_cycles = '0;
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder (N=4, DATA_W=8) with a downstream 4x4 MAC array model.
module tb_systolic_feeder;

  localparam int DW = 8;
  localparam int N  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_valid;
  logic          wr_ready;
  logic          wr_sel;
  logic [1:0]    wr_row;
  logic [31:0]   wr_data;
  logic          start;
  logic          busy;
  logic          done;
  logic          pe_rst;
  logic          pe_en;
  logic [31:0]   a_edge;
  logic [31:0]   b_edge;
  logic [31:0]   feed_cycles;
  logic [1:0]    dbg_state;

  systolic_feeder #(.DATA_W(DW), .N(N)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_sel(wr_sel),
    .wr_row(wr_row), .wr_data(wr_data),
    .start(start), .busy(busy), .done(done),
    .pe_rst(pe_rst), .pe_en(pe_en),
    .a_edge(a_edge), .b_edge(b_edge),
    .feed_cycles(feed_cycles), .dbg_state(dbg_state)
  );

  // ---- clock / reset ----
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---- scoreboard state ----
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  logic [7:0]  ma [4][4];
  logic [7:0]  mb [4][4];
  logic [31:0] a_tr [10];
  logic [31:0] b_tr [10];
  int          lat;
  int          snap_en, snap_rst, snap_done;

  // ---- downstream 4x4 output-stationary MAC array, sampled mid-cycle ----
  logic [7:0]  pa  [4][4];
  logic [7:0]  pb  [4][4];
  logic [31:0] acc [4][4];
  int          pe_en_tot = 0;
  int          pe_rst_tot = 0;
  int          done_tot = 0;

  always @(negedge clk) begin : pe_model
    logic [7:0] ain;
    logic [7:0] bin;
    if (pe_en)  pe_en_tot  <= pe_en_tot + 1;
    if (pe_rst) pe_rst_tot <= pe_rst_tot + 1;
    if (done)   done_tot   <= done_tot + 1;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        ain = (j == 0) ? a_edge[i*8 +: 8] : pa[i][(j == 0) ? 0 : j-1];
        bin = (i == 0) ? b_edge[j*8 +: 8] : pb[(i == 0) ? 0 : i-1][j];
        if (pe_rst) begin
          pa[i][j]  <= '0;
          pb[i][j]  <= '0;
          acc[i][j] <= '0;
        end else if (pe_en) begin
          pa[i][j]  <= ain;
          pb[i][j]  <= bin;
          acc[i][j] <= acc[i][j] + 32'(ain) * 32'(bin);
        end
      end
    end
  end

  // ---- expected edge values from the bench's own copy of the buffers ----
  function automatic logic [31:0] exp_a(input int t);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < 4; i++)
      if (t - i >= 0 && t - i < 4) v[i*8 +: 8] = ma[i][t-i];
    return v;
  endfunction

  function automatic logic [31:0] exp_b(input int t);
    logic [31:0] v;
    v = '0;
    for (int j = 0; j < 4; j++)
      if (t - j >= 0 && t - j < 4) v[j*8 +: 8] = mb[t-j][j];
    return v;
  endfunction

  function automatic logic [31:0] row_of(input logic sel, input int r);
    logic [31:0] v;
    for (int k = 0; k < 4; k++) v[k*8 +: 8] = sel ? mb[r][k] : ma[r][k];
    return v;
  endfunction

  // ---- driver tasks ----
  task automatic write_row(input logic sel, input int r);
    wr_valid = 1'b1;
    wr_sel   = sel;
    wr_row   = 2'(r);
    wr_data  = row_of(sel, r);
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic write_all();
    for (int r = 0; r < 4; r++) begin
      write_row(1'b0, r);
      write_row(1'b1, r);
    end
  endtask

  // Starts a pass and follows it cycle by cycle; inj>0 drives start+write in that cycle.
  task automatic run_pass(input int inj, output int latency);
    start = 1'b1;
    tick();
    start = 1'b0;
    latency = -1;
    for (int k = 1; k <= 40; k++) begin
      if (k == 1) begin
        check("clear_ctl", {62'd0, pe_rst, pe_en}, 64'b10);
        check("clear_edges", {a_edge, b_edge}, 64'd0);
      end else if (k <= 11) begin
        a_tr[k-2] = a_edge;
        b_tr[k-2] = b_edge;
        check("feed_a", {32'd0, a_edge}, {32'd0, exp_a(k-2)});
        check("feed_b", {32'd0, b_edge}, {32'd0, exp_b(k-2)});
        check("feed_ctl", {61'd0, pe_en, pe_rst, busy}, 64'b101);
      end
      if (done) begin
        latency = k;
        check("done_quiet", {31'd0, pe_en, a_edge, b_edge}, 64'd0);
        break;
      end
      if (k == inj) begin
        check("wr_ready_busy", {63'd0, wr_ready}, 64'd0);
        start    = 1'b1;
        wr_valid = 1'b1;
        wr_sel   = 1'b0;
        wr_row   = 2'd1;
        wr_data  = 32'hffff_ffff;
      end
      tick();
      start    = 1'b0;
      wr_valid = 1'b0;
    end
    if (latency < 0) begin
      check("pass_timeout", 64'd0, 64'd1);
    end else begin
      tick();
      check("idle_after", {61'd0, busy, done, wr_ready}, 64'b001);
    end
  endtask

  // ---- directed tests ----
  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_sel = 1'b0; wr_row = '0; wr_data = '0; start = 1'b0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin ma[r][c] = '0; mb[r][c] = '0; end
    tick();
    tick();
    rst = 1'b0;
    check("rst_ctl", {59'd0, busy, done, pe_rst, pe_en, wr_ready}, 64'b00001);
    check("rst_edges", {a_edge, b_edge}, 64'd0);
    check("rst_state", {62'd0, dbg_state}, 64'd0);
    check("rst_perf", {32'd0, feed_cycles}, 64'd0);

    // T1: A = identity, B[r][c] = 4r+c+1
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        ma[r][c] = (r == c) ? 8'd1 : 8'd0;
        mb[r][c] = 8'(4*r + c + 1);
      end
    check("wr_ready_idle", {63'd0, wr_ready}, 64'd1);
    write_all();
    run_pass(0, lat);
    check("t1_latency", 64'(lat), 64'd12);
    check("t1_a_t0", {32'd0, a_tr[0]}, 64'h0000_0001);
    check("t1_b_t0", {32'd0, b_tr[0]}, 64'h0000_0001);
    check("t1_b_t1", {32'd0, b_tr[1]}, 64'h0000_0205);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        check("t1_acc", {32'd0, acc[r][c]}, 64'(4*r + c + 1));

    // T2: A all 2, B all 3
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin ma[r][c] = 8'd2; mb[r][c] = 8'd3; end
    write_all();
    snap_en = pe_en_tot; snap_rst = pe_rst_tot;
    run_pass(0, lat);
    check("t2_pe_en_cycles", 64'(pe_en_tot - snap_en), 64'd10);
    check("t2_pe_rst_cycles", 64'(pe_rst_tot - snap_rst), 64'd1);
    check("t2_a_t0", {32'd0, a_tr[0]}, 64'h0000_0002);
    check("t2_b_t0", {32'd0, b_tr[0]}, 64'h0000_0003);
    check("t2_a_t3", {32'd0, a_tr[3]}, 64'h0202_0202);
    check("t2_b_t3", {32'd0, b_tr[3]}, 64'h0303_0303);
    check("t2_edges_t9", {a_tr[9], b_tr[9]}, 64'd0);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        check("t2_acc", {32'd0, acc[r][c]}, 64'd24);

    // T3: write A row 0 = 5s in the same cycle as start
    for (int c = 0; c < 4; c++) ma[0][c] = 8'd5;
    wr_valid = 1'b1; wr_sel = 1'b0; wr_row = 2'd0; wr_data = 32'h0505_0505;
    run_pass(0, lat);
    check("t3_latency", 64'(lat), 64'd12);
    check("t3_acc00", {32'd0, acc[0][0]}, 64'd60);
    check("t3_acc11", {32'd0, acc[1][1]}, 64'd24);

    // T4: start + write during FEED are ignored; one done only
    snap_done = done_tot;
    run_pass(5, lat);
    check("t4_latency", 64'(lat), 64'd12);
    for (int k = 0; k < 15; k++) tick();
    check("t4_done_pulses", 64'(done_tot - snap_done), 64'd1);
    check("t4_idle", {62'd0, busy, wr_ready}, 64'b01);
    run_pass(0, lat);
    check("t4_acc11_kept", {32'd0, acc[1][1]}, 64'd24);
    check("t4_acc03_kept", {32'd0, acc[0][3]}, 64'd60);

    // T5: reset at FEED t=5 aborts the pass and clears the buffers
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    check("t5_at_t5", {32'd0, a_edge}, {32'd0, exp_a(5)});
    snap_done = done_tot;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_after_rst", {59'd0, busy, done, pe_en, pe_rst, wr_ready}, 64'b00001);
    check("t5_state", {62'd0, dbg_state}, 64'd0);
    check("t5_perf_clr", {32'd0, feed_cycles}, 64'd0);
    for (int k = 0; k < 15; k++) tick();
    check("t5_no_done", 64'(done_tot - snap_done), 64'd0);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin ma[r][c] = '0; mb[r][c] = '0; end
    run_pass(0, lat);
    check("t5_latency", 64'(lat), 64'd12);
    check("t5_acc33", {32'd0, acc[3][3]}, 64'd0);
    check("t5_acc00", {32'd0, acc[0][0]}, 64'd0);

    // T6: performance counter after two passes since reset
    run_pass(0, lat);
`ifdef SYSTOLIC_FEEDER_PERF_CNT_EN
    check("perf_two_passes", {32'd0, feed_cycles}, 64'd20);
`else
    check("perf_two_passes", {32'd0, feed_cycles}, 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
